// File: rtl/poci_pkg.sv
// Shared types and constants for the POCI readout slice.
//   BYTE_W        : width of one config register / shifted byte
//   byte_t        : one byte
//   poci_state_t  : shifter FSM states
//   RESERVED_ADDR : address 0, never backed by a register
package poci_pkg;
  localparam int BYTE_W = 8;
  typedef logic [BYTE_W-1:0] byte_t;
  typedef enum logic {ST_IDLE, ST_SHIFT} poci_state_t;
  localparam byte_t RESERVED_ADDR = 8'h00;
endpackage

// File: rtl/poci_readout_if.sv
// Upstream byte bus from the PICO path into the readout stage.
//   byte_valid : one-cycle byte boundary strobe
//   wr_en      : 1 = data phase (write), 0 = pointer phase (read only)
//   addr       : address pointer
//   wdata      : write data
// master = upstream PICO stage, slave = poci_readout.
interface poci_readout_if;
  import poci_pkg::*;
  logic  byte_valid;
  logic  wr_en;
  byte_t addr;
  byte_t wdata;

  modport master (output byte_valid, wr_en, addr, wdata);
  modport slave  (input  byte_valid, wr_en, addr, wdata);
endinterface

// File: rtl/poci_p2s_shifter.sv
// Parallel-to-serial shifter for the POCI line, MSB first, one bit per sclk.
//   sclk, rstn  : clock, async active-low reset
//   load        : take load_data and restart the byte
//   load_data   : byte to shift out
//   serial_out  : POCI bit (0 while idle)
//   busy        : high while a byte is being shifted
//   overrun     : sticky, set when a load abandons a partially sent byte
//   parity_out  : (POCI_PARITY_EN only) odd parity of the last loaded byte
// Optional feature macro: POCI_PARITY_EN.
module poci_p2s_shifter
  import poci_pkg::*;
(
  input  logic  sclk,
  input  logic  rstn,
  input  logic  load,
  input  byte_t load_data,
  output logic  serial_out,
  output logic  busy,
`ifdef POCI_PARITY_EN
  output logic  parity_out,
`endif
  output logic  overrun
);
  poci_state_t state;
  byte_t       shifter;
  logic [2:0]  bit_cnt;

  // serial_out/busy are registered alongside the state so they track it
  // exactly: serial_out always equals shifter[7] while shifting.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      shifter    <= '0;
      bit_cnt    <= '0;
      serial_out <= 1'b0;
      busy       <= 1'b0;
      overrun    <= 1'b0;
    end else if (load) begin
      // A load on the last bit is a seamless back-to-back; earlier is a loss.
      if (state == ST_SHIFT && bit_cnt != 3'd7) overrun <= 1'b1;
      state      <= ST_SHIFT;
      shifter    <= load_data;
      bit_cnt    <= '0;
      serial_out <= load_data[7];
      busy       <= 1'b1;
    end else if (state == ST_SHIFT) begin
      shifter <= {shifter[6:0], 1'b0};
      if (bit_cnt == 3'd7) begin
        state      <= ST_IDLE;
        bit_cnt    <= '0;
        serial_out <= 1'b0;
        busy       <= 1'b0;
      end else begin
        bit_cnt    <= bit_cnt + 3'd1;
        serial_out <= shifter[6];
      end
    end
  end

`ifdef POCI_PARITY_EN
  // Reset value 1 is the odd parity of the all-zero byte.
  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn)     parity_out <= 1'b1;
    else if (load) parity_out <= ~^load_data;
  end
`endif
endmodule

// File: rtl/poci_readout.sv
// POCI readout stage: config register bank written from the PICO byte bus,
// addressed register serialized back on POCI.
//   sclk, rstn  : clock, async active-low reset
//   up          : upstream byte bus (slave modport)
//   serial_out  : POCI bit, busy : shifting, overrun : sticky early-reload flag
//   cfg_regs    : flat bank, address k+1 at bits [8k+7:8k]
//   parity_out  : (POCI_PARITY_EN only) odd parity of the loaded byte
// Optional feature macro: POCI_PARITY_EN.
module poci_readout
  import poci_pkg::*;
#(
  parameter int    NUM_REGS = 16,
  parameter byte_t RST_VAL  = 8'h00
) (
  input  logic                       sclk,
  input  logic                       rstn,
  poci_readout_if.slave              up,
  output logic                       serial_out,
  output logic                       busy,
  output logic                       overrun,
`ifdef POCI_PARITY_EN
  output logic                       parity_out,
`endif
  output logic [NUM_REGS*BYTE_W-1:0] cfg_regs
);
  logic [NUM_REGS-1:0][BYTE_W-1:0] regs;
  logic  in_range;
  byte_t rd_val;

  assign in_range = (up.addr != RESERVED_ADDR) && (int'(up.addr) <= NUM_REGS);
  assign cfg_regs = regs;

  always_ff @(posedge sclk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= RST_VAL;
    end else if (up.byte_valid && up.wr_en) begin
      for (int k = 0; k < NUM_REGS; k++)
        if (up.addr == 8'(k + 1)) regs[k] <= up.wdata;
    end
  end

  // Out-of-range addresses match no register and read as zero; a write in
  // the same cycle bypasses the bank so the fresh value is shifted out.
  always_comb begin
    rd_val = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (up.addr == 8'(k + 1)) rd_val = regs[k];
    if (up.wr_en && in_range) rd_val = up.wdata;
  end

  poci_p2s_shifter u_shifter (
    .sclk       (sclk),
    .rstn       (rstn),
    .load       (up.byte_valid),
    .load_data  (rd_val),
    .serial_out (serial_out),
    .busy       (busy),
`ifdef POCI_PARITY_EN
    .parity_out (parity_out),
`endif
    .overrun    (overrun)
  );
endmodule

// File: tb/tb_poci_readout.sv
module tb_poci_readout;
  import poci_pkg::*;
  localparam int NR = 16;

  logic sclk = 1'b0;
  logic rstn = 1'b0;
  always #5 sclk = ~sclk;

  poci_readout_if bus();
  logic serial_out, busy, overrun;
  logic [NR*8-1:0] cfg_regs;
`ifdef POCI_PARITY_EN
  logic parity_out;
`endif

  poci_readout #(.NUM_REGS(NR), .RST_VAL(8'h00)) dut (
    .sclk       (sclk),
    .rstn       (rstn),
    .up         (bus),
    .serial_out (serial_out),
    .busy       (busy),
    .overrun    (overrun),
`ifdef POCI_PARITY_EN
    .parity_out (parity_out),
`endif
    .cfg_regs   (cfg_regs)
  );

  int checks = 0;
  int errors = 0;
  logic [NR*8-1:0] exp_cfg = '0;

  task automatic tick();
    @(posedge sclk); #1;
  endtask

  task automatic strobe(input logic w, input byte_t a, input byte_t d);
    bus.byte_valid = 1'b1; bus.wr_en = w; bus.addr = a; bus.wdata = d;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (cfg_regs !== '0 || serial_out !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset: cfg=%h so=%b busy=%b ovr=%b want all 0", cfg_regs, serial_out, busy, overrun);
    end
`ifdef POCI_PARITY_EN
    checks++;
    if (parity_out !== 1'b1) begin errors++; $display("FAIL reset_parity: %b want 1", parity_out); end
`endif
    @(negedge sclk); rstn = 1'b1;
    tick();
  endtask

  // 0xA5 written to addr 3, bypassed straight into the shifter.
  task automatic test_write_shift();
    byte_t e = 8'hA5;
    strobe(1'b1, 8'd3, 8'hA5);
    exp_cfg[2*8 +: 8] = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      tick();
      bus.byte_valid = 1'b0;
      if (i == 0) begin
        checks++;
        if (cfg_regs !== exp_cfg) begin errors++; $display("FAIL write_reg3: cfg=%h want %h", cfg_regs, exp_cfg); end
`ifdef POCI_PARITY_EN
        // 0xA5 has four ones, so the odd-parity bit is 1.
        checks++;
        if (parity_out !== 1'b1) begin errors++; $display("FAIL parity_a5: %b want 1", parity_out); end
`endif
      end
      checks++;
      if (serial_out !== e[7-i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL write_shift bit%0d: so=%b busy=%b want %b 1", i, serial_out, busy, e[7-i]);
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0 || serial_out !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL write_idle: busy=%b so=%b ovr=%b want 0 0 0", busy, serial_out, overrun);
    end
  endtask

  // Write 0x3C to addr 5, let it drain, then read it back in pointer phase.
  task automatic test_read();
    byte_t e = 8'h3C;
    strobe(1'b1, 8'd5, 8'h3C);
    exp_cfg[4*8 +: 8] = 8'h3C;
    tick(); bus.byte_valid = 1'b0;
    repeat (8) tick();
    strobe(1'b0, 8'd5, 8'hEE);
    for (int i = 0; i < 8; i++) begin
      tick();
      bus.byte_valid = 1'b0;
      checks++;
      if (serial_out !== e[7-i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL read_shift bit%0d: so=%b busy=%b want %b 1", i, serial_out, busy, e[7-i]);
      end
    end
    checks++;
    if (cfg_regs !== exp_cfg) begin errors++; $display("FAIL read_noreg: cfg=%h want %h", cfg_regs, exp_cfg); end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL read_idle: busy=%b want 0", busy); end
  endtask

  // Strobes 8 cycles apart: 0xFF then 0x81 with no gap.
  task automatic test_back_to_back();
    logic [15:0] e = 16'hFF81;
    strobe(1'b1, 8'd2, 8'hFF);
    exp_cfg[1*8 +: 8] = 8'hFF;
    exp_cfg[2*8 +: 8] = 8'h81;
    for (int i = 0; i < 16; i++) begin
      tick();
      bus.byte_valid = 1'b0;
      if (i == 7) strobe(1'b1, 8'd3, 8'h81);
      checks++;
      if (serial_out !== e[15-i] || busy !== 1'b1 || overrun !== 1'b0) begin
        errors++;
        $display("FAIL b2b bit%0d: so=%b busy=%b ovr=%b want %b 1 0", i, serial_out, busy, overrun, e[15-i]);
      end
    end
    tick();
    checks++;
    if (busy !== 1'b0 || cfg_regs !== exp_cfg) begin
      errors++;
      $display("FAIL b2b_end: busy=%b cfg=%h want 0 %h", busy, cfg_regs, exp_cfg);
    end
  endtask

  // Read 0x3C, reload after 4 bits with 0xFF: expect 0011 then 11111111.
  task automatic test_early_reload();
    logic [11:0] e = 12'b0011_1111_1111;
    strobe(1'b0, 8'd5, 8'h00);
    for (int i = 0; i < 12; i++) begin
      tick();
      bus.byte_valid = 1'b0;
      if (i == 3) begin
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("FAIL early_pre_ovr: %b want 0", overrun); end
        strobe(1'b0, 8'd2, 8'h00);
      end
      checks++;
      if (serial_out !== e[11-i] || busy !== 1'b1) begin
        errors++;
        $display("FAIL early bit%0d: so=%b busy=%b want %b 1", i, serial_out, busy, e[11-i]);
      end
    end
    tick();
    checks++;
    if (overrun !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL early_ovr: ovr=%b busy=%b want 1 0", overrun, busy);
    end
  endtask

  task automatic test_out_of_range();
    byte_t addrs [4] = '{8'd0, 8'(NR + 1), 8'd0, 8'd255};
    logic  wrs   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int t = 0; t < 4; t++) begin
      strobe(wrs[t], addrs[t], 8'h77);
      for (int i = 0; i < 8; i++) begin
        tick();
        bus.byte_valid = 1'b0;
        checks++;
        if (serial_out !== 1'b0 || busy !== 1'b1) begin
          errors++;
          $display("FAIL oor%0d bit%0d: so=%b busy=%b want 0 1", t, i, serial_out, busy);
        end
      end
`ifdef POCI_PARITY_EN
      checks++;
      if (parity_out !== 1'b1) begin errors++; $display("FAIL oor%0d_parity: %b want 1", t, parity_out); end
`endif
      checks++;
      if (cfg_regs !== exp_cfg || overrun !== 1'b1) begin
        errors++;
        $display("FAIL oor%0d_regs: cfg=%h ovr=%b want %h 1", t, cfg_regs, overrun, exp_cfg);
      end
    end
    tick();
  endtask

  task automatic test_reset_mid_shift();
    strobe(1'b0, 8'd2, 8'h00);
    tick(); bus.byte_valid = 1'b0;
    tick(); tick();
    checks++;
    if (serial_out !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre: so=%b busy=%b want 1 1", serial_out, busy);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if (cfg_regs !== '0 || serial_out !== 1'b0 || busy !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: cfg=%h so=%b busy=%b ovr=%b want all 0", cfg_regs, serial_out, busy, overrun);
    end
    @(negedge sclk); rstn = 1'b1;
    tick(); tick();
    checks++;
    if (serial_out !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL mid_after: so=%b busy=%b want 0 0", serial_out, busy);
    end
  endtask

  initial begin
    bus.byte_valid = 1'b0; bus.wr_en = 1'b0; bus.addr = '0; bus.wdata = '0;
    test_reset();
    test_write_shift();
    test_read();
    test_back_to_back();
    test_early_reload();
    test_out_of_range();
    test_reset_mid_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
